muldiv_controller: RTL

- Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS datapath.
- Sits beside the execute stage. Accepts MULT/MULTU/DIV/DIVU from ID/EX and runs a radix-2 shift-add or restoring-divide loop.
- Holds the pipeline through its Stall output when a later instruction needs HI/LO or the unit while it is busy.
- Also services MTHI/MTLO direct writes and drives HIRegOutput/LORegOutput to the top level.

---
 rtl/muldiv_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_controller.sv
// rtl/muldiv_controller.sv - iterative MIPS multiply/divide sequencer owning HI/LO
// Optional feature macro: MULDIV_FAST_MULT_EN (single-cycle multiplier in PREP, skips ITER for MULT/MULTU)
module muldiv_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  input  logic                  Flush,
  input  logic                  HiLoRead,
  input  logic                  WriteHi,
  input  logic                  WriteLo,
  input  logic [DATA_WIDTH-1:0] WriteHiLoData,
  output logic                  Busy,
  output logic                  Stall,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HIRegOutput,
  output logic [DATA_WIDTH-1:0] LORegOutput
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIXUP} state_t;

  state_t                state, nextState;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] hiReg, loReg;
  logic [DATA_WIDTH-1:0] aReg, bReg;
  logic [DATA_WIDTH-1:0] workHi, workLo, workDiv;
  logic                  isDivReg, signA, signB;
  logic                  doneReg, dbzReg;

  // Magnitudes of the latched operands; sign flags are only ever set for signed ops
  logic [DATA_WIDTH-1:0] absA, absB;
  assign absA = signA ? (-aReg) : aReg;
  assign absB = signB ? (-bReg) : bReg;

  logic lastIter;
  assign lastIter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  // Shift-add step: {carry, workHi, workLo} shifts right after the conditional add
  logic [DATA_WIDTH:0] multSum;
  assign multSum = {1'b0, workHi} + (workLo[0] ? {1'b0, workDiv} : {(DATA_WIDTH+1){1'b0}});

  // Restoring-divide step: the partial remainder always stays below the divisor, so W bits suffice
  logic [DATA_WIDTH:0]   divShift;
  logic [DATA_WIDTH-1:0] divDiff;
  logic                  divFits;
  assign divShift = {workHi, workLo[DATA_WIDTH-1]};
  assign divFits  = (divShift >= {1'b0, workDiv});
  assign divDiff  = divShift[DATA_WIDTH-1:0] - workDiv;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*DATA_WIDTH-1:0] fastProduct;
  assign fastProduct = {{DATA_WIDTH{1'b0}}, absA} * {{DATA_WIDTH{1'b0}}, absB};
`endif

  // Sign correction and divide-by-zero override applied when leaving FIXUP
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   resHi, resLo;
  logic                    divZero;
  assign divZero = (bReg == '0);
  always_comb begin
    product = {workHi, workLo};
    resHi   = workHi;
    resLo   = workLo;
    if (isDivReg) begin
      if (divZero) begin
        resHi = aReg;
        resLo = '1;
      end else begin
        resLo = (signA ^ signB) ? (-workLo) : workLo;
        resHi = signA ? (-workHi) : workHi;
      end
    end else begin
      if (signA ^ signB) product = -product;
      resHi = product[2*DATA_WIDTH-1:DATA_WIDTH];
      resLo = product[DATA_WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (Start && !Flush) nextState = PREP;
`ifdef MULDIV_FAST_MULT_EN
      PREP:  nextState = isDivReg ? ITER : FIXUP;
`else
      PREP:  nextState = ITER;
`endif
      ITER:  if (lastIter) nextState = FIXUP;
      FIXUP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs; requests arriving while busy are held off and re-presented later
  always_comb begin
    Busy  = (state != IDLE);
    Stall = Busy & (HiLoRead | Start | WriteHi | WriteLo);
  end

  // Operand latch, iteration datapath and HI/LO register pair
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt      <= '0;
      hiReg    <= '0;
      loReg    <= '0;
      aReg     <= '0;
      bReg     <= '0;
      workHi   <= '0;
      workLo   <= '0;
      workDiv  <= '0;
      isDivReg <= 1'b0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      doneReg  <= 1'b0;
      dbzReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (WriteHi) hiReg <= WriteHiLoData;
          if (WriteLo) loReg <= WriteHiLoData;
          if (Start && !Flush) begin
            aReg     <= OperandA;
            bReg     <= OperandB;
            isDivReg <= Op[1];
            signA    <= ~Op[0] & OperandA[DATA_WIDTH-1];
            signB    <= ~Op[0] & OperandB[DATA_WIDTH-1];
          end
        end
        PREP: begin
          cnt    <= '0;
          workHi <= '0;
          if (isDivReg) begin
            workLo  <= absA;
            workDiv <= absB;
          end else begin
            workLo  <= absB;
            workDiv <= absA;
`ifdef MULDIV_FAST_MULT_EN
            workHi  <= fastProduct[2*DATA_WIDTH-1:DATA_WIDTH];
            workLo  <= fastProduct[DATA_WIDTH-1:0];
`endif
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (isDivReg) begin
            workHi <= divFits ? divDiff : divShift[DATA_WIDTH-1:0];
            workLo <= {workLo[DATA_WIDTH-2:0], divFits};
          end else begin
            workHi <= multSum[DATA_WIDTH:1];
            workLo <= {multSum[0], workLo[DATA_WIDTH-1:1]};
          end
        end
        FIXUP: begin
          hiReg   <= resHi;
          loReg   <= resLo;
          doneReg <= 1'b1;
          dbzReg  <= isDivReg & divZero;
        end
        default: ;
      endcase
    end
  end

  assign Done        = doneReg;
  assign DivByZero   = dbzReg;
  assign HIRegOutput = hiReg;
  assign LORegOutput = loReg;

endmodule
